// File: rtl/lut_eval.sv
// Run-time programmable N-input truth-table evaluator with serial table load.
// Define LUT_EVAL_SWEEP_EN to add the exhaustive sweep engine; otherwise its outputs are tied to 0.
module lut_eval #(
  parameter int N_IN = 4,
  parameter logic [(1<<N_IN)-1:0] INIT_TT = {1'b1, {((1<<N_IN)-1){1'b0}}}
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N_IN-1:0] in_i,
  input  logic            in_valid_i,
  output logic            y_o,
  output logic            y_valid_o,
  input  logic            cfg_start_i,
  input  logic            cfg_bit_i,
  input  logic            cfg_valid_i,
  output logic            cfg_done_o,
  input  logic            sweep_start_i,
  output logic            sweep_busy_o,
  output logic [N_IN-1:0] sweep_idx_o,
  output logic            sweep_y_o,
  output logic            sweep_valid_o,
  output logic            sweep_done_o,
  output logic [N_IN:0]   ones_o
);

  localparam int TT = 1 << N_IN;
  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(TT - 1);

  logic [TT-1:0]   active_tt_reg;
  logic [TT-1:0]   shadow_tt_reg;
  logic [TT-1:0]   shadow_tt_next;
  logic [N_IN-1:0] bit_cnt_reg;
  logic            y_reg;
  logic            y_valid_reg;
  logic            cfg_done_reg;
  logic            eval_en;

  // Shadow table with the incoming serial bit merged at the current load position.
  generate
    for (genvar gi = 0; gi < TT; gi++) begin : g_shadow
      assign shadow_tt_next[gi] = (cfg_valid_i && (bit_cnt_reg == N_IN'(gi))) ? cfg_bit_i
                                                                               : shadow_tt_reg[gi];
    end
  endgenerate

`ifdef LUT_EVAL_SWEEP_EN
  typedef enum logic [1:0] {IDLE, LOAD, SWEEP} state_t;

  // One extra counter bit lets N_IN = 8 reach TT without wrapping to 0.
  localparam logic [N_IN:0] CNT_END = (N_IN+1)'(TT);

  logic [N_IN:0]   cnt_reg;
  logic [N_IN-1:0] sweep_idx_reg;
  logic            sweep_y_reg;
  logic            sweep_valid_reg;
  logic            sweep_done_reg;
  logic [N_IN:0]   ones_reg;
`else
  typedef enum logic {IDLE, LOAD} state_t;
`endif

  state_t state_reg;

`ifdef LUT_EVAL_SWEEP_EN
  assign eval_en = (state_reg != SWEEP);
`else
  assign eval_en = 1'b1;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg       <= IDLE;
      active_tt_reg   <= INIT_TT;
      shadow_tt_reg   <= '0;
      bit_cnt_reg     <= '0;
      y_reg           <= 1'b0;
      y_valid_reg     <= 1'b0;
      cfg_done_reg    <= 1'b0;
`ifdef LUT_EVAL_SWEEP_EN
      cnt_reg         <= '0;
      sweep_idx_reg   <= '0;
      sweep_y_reg     <= 1'b0;
      sweep_valid_reg <= 1'b0;
      sweep_done_reg  <= 1'b0;
      ones_reg        <= '0;
`endif
    end else begin
      cfg_done_reg <= 1'b0;

      if (in_valid_i && eval_en) begin
        y_reg       <= active_tt_reg[in_i];
        y_valid_reg <= 1'b1;
      end else begin
        y_valid_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          // A load request takes priority over a simultaneous sweep request.
          if (cfg_start_i) begin
            state_reg   <= LOAD;
            bit_cnt_reg <= '0;
          end
`ifdef LUT_EVAL_SWEEP_EN
          else if (sweep_start_i) begin
            state_reg       <= SWEEP;
            cnt_reg         <= (N_IN+1)'(1);
            sweep_idx_reg   <= '0;
            sweep_y_reg     <= active_tt_reg[0];
            sweep_valid_reg <= 1'b1;
            sweep_done_reg  <= 1'b0;
            ones_reg        <= {{N_IN{1'b0}}, active_tt_reg[0]};
          end
`endif
        end

        LOAD: begin
          if (cfg_valid_i) begin
            shadow_tt_reg <= shadow_tt_next;
            bit_cnt_reg   <= bit_cnt_reg + N_IN'(1);
            if (bit_cnt_reg == LAST_IDX) begin
              active_tt_reg <= shadow_tt_next;
              cfg_done_reg  <= 1'b1;
              bit_cnt_reg   <= '0;
              state_reg     <= IDLE;
            end
          end
        end

`ifdef LUT_EVAL_SWEEP_EN
        SWEEP: begin
          if (cnt_reg == CNT_END) begin
            state_reg       <= IDLE;
            sweep_valid_reg <= 1'b0;
            sweep_done_reg  <= 1'b0;
          end else begin
            sweep_idx_reg  <= cnt_reg[N_IN-1:0];
            sweep_y_reg    <= active_tt_reg[cnt_reg[N_IN-1:0]];
            ones_reg       <= ones_reg + {{N_IN{1'b0}}, active_tt_reg[cnt_reg[N_IN-1:0]]};
            sweep_done_reg <= (cnt_reg[N_IN-1:0] == LAST_IDX);
            cnt_reg        <= cnt_reg + (N_IN+1)'(1);
          end
        end
`endif

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign y_o        = y_reg;
  assign y_valid_o  = y_valid_reg;
  assign cfg_done_o = cfg_done_reg;

`ifdef LUT_EVAL_SWEEP_EN
  assign sweep_busy_o  = sweep_valid_reg;
  assign sweep_idx_o   = sweep_idx_reg;
  assign sweep_y_o     = sweep_y_reg;
  assign sweep_valid_o = sweep_valid_reg;
  assign sweep_done_o  = sweep_done_reg;
  assign ones_o        = ones_reg;
`else
  logic unused_sweep_start;
  assign unused_sweep_start = sweep_start_i;

  assign sweep_busy_o  = 1'b0;
  assign sweep_idx_o   = '0;
  assign sweep_y_o     = 1'b0;
  assign sweep_valid_o = 1'b0;
  assign sweep_done_o  = 1'b0;
  assign ones_o        = '0;
`endif

endmodule

// File: tb/tb_lut_eval.sv
// Directed self-checking bench for lut_eval: N_IN=4 main instance plus N_IN=1 and N_IN=8 sweep instances.
module tb_lut_eval;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [3:0] in_v = '0;
  logic       in_valid = 1'b0;
  logic       cfg_start = 1'b0;
  logic       cfg_bit = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       sweep_start = 1'b0;

  logic       y, y_valid, cfg_done, sweep_busy, sweep_y, sweep_valid, sweep_done;
  logic [3:0] sweep_idx;
  logic [4:0] ones;

  logic [0:0] d1_in = '0;
  logic       d1_in_valid = 1'b0;
  logic       s1_start = 1'b0;
  logic       d1_y, d1_y_valid, d1_cfg_done, d1_busy, d1_sweep_y, d1_valid, d1_done;
  logic [0:0] d1_idx;
  logic [1:0] d1_ones;

  logic       s8_start = 1'b0;
  logic       d8_y, d8_y_valid, d8_cfg_done, d8_busy, d8_sweep_y, d8_valid, d8_done;
  logic [7:0] d8_idx;
  logic [8:0] d8_ones;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] xor_tt = 16'h6996;

  lut_eval #(.N_IN(4)) dut (
    .clk_i(clk), .rst_i(rst), .in_i(in_v), .in_valid_i(in_valid),
    .y_o(y), .y_valid_o(y_valid),
    .cfg_start_i(cfg_start), .cfg_bit_i(cfg_bit), .cfg_valid_i(cfg_valid), .cfg_done_o(cfg_done),
    .sweep_start_i(sweep_start), .sweep_busy_o(sweep_busy), .sweep_idx_o(sweep_idx),
    .sweep_y_o(sweep_y), .sweep_valid_o(sweep_valid), .sweep_done_o(sweep_done), .ones_o(ones)
  );

  lut_eval #(.N_IN(1), .INIT_TT(2'b01)) dut1 (
    .clk_i(clk), .rst_i(rst), .in_i(d1_in), .in_valid_i(d1_in_valid),
    .y_o(d1_y), .y_valid_o(d1_y_valid),
    .cfg_start_i(1'b0), .cfg_bit_i(1'b0), .cfg_valid_i(1'b0), .cfg_done_o(d1_cfg_done),
    .sweep_start_i(s1_start), .sweep_busy_o(d1_busy), .sweep_idx_o(d1_idx),
    .sweep_y_o(d1_sweep_y), .sweep_valid_o(d1_valid), .sweep_done_o(d1_done), .ones_o(d1_ones)
  );

  lut_eval #(.N_IN(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .in_i(8'h00), .in_valid_i(1'b0),
    .y_o(d8_y), .y_valid_o(d8_y_valid),
    .cfg_start_i(1'b0), .cfg_bit_i(1'b0), .cfg_valid_i(1'b0), .cfg_done_o(d8_cfg_done),
    .sweep_start_i(s8_start), .sweep_busy_o(d8_busy), .sweep_idx_o(d8_idx),
    .sweep_y_o(d8_sweep_y), .sweep_valid_o(d8_valid), .sweep_done_o(d8_done), .ones_o(d8_ones)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("  ok %s = %0h", tag, obs);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    step();
    step();
    check("rst_y", y, 0);
    check("rst_y_valid", y_valid, 0);
    check("rst_cfg_done", cfg_done, 0);
    check("rst_busy", sweep_busy, 0);
    check("rst_ones", ones, 0);
    check("rst_idx", sweep_idx, 0);
    rst = 1'b0;
    step();
    check("post_rst_y_valid", y_valid, 0);

    // Default table: AND of all four inputs.
    for (int i = 0; i < 16; i++) begin
      in_v = 4'(i);
      in_valid = 1'b1;
      step();
      check($sformatf("and_y[%0d]", i), y, (i == 15) ? 1 : 0);
      check($sformatf("and_vld[%0d]", i), y_valid, 1);
    end
    in_valid = 1'b0;
    step();
    check("idle_y_valid", y_valid, 0);
    check("idle_y_hold", y, 1);

`ifdef LUT_EVAL_SWEEP_EN
    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("sw0_valid[%0d]", k), sweep_valid, 1);
      check($sformatf("sw0_idx[%0d]", k), sweep_idx, k);
      check($sformatf("sw0_y[%0d]", k), sweep_y, (k == 15) ? 1 : 0);
      check($sformatf("sw0_done[%0d]", k), sweep_done, (k == 15) ? 1 : 0);
      check($sformatf("sw0_y_valid[%0d]", k), y_valid, 0);
      if (k == 15) check("sw0_ones", ones, 1);
      step();
    end
    in_valid = 1'b0;
    check("sw0_end_busy", sweep_busy, 0);
    check("sw0_end_valid", sweep_valid, 0);
    check("sw0_end_y_valid", y_valid, 0);
    check("sw0_ones_hold", ones, 1);
`else
    sweep_start = 1'b1;
    in_valid = 1'b1;
    step();
    sweep_start = 1'b0;
    in_valid = 1'b0;
    check("nosw_busy", sweep_busy, 0);
    check("nosw_valid", sweep_valid, 0);
    check("nosw_ones", ones, 0);
    check("nosw_y_valid", y_valid, 1);
`endif

    // Load XOR4 with simultaneous start requests and gaps; evaluate in=1 throughout.
    cfg_start = 1'b1;
    sweep_start = 1'b1;
    in_v = 4'b0001;
    in_valid = 1'b1;
    step();
    cfg_start = 1'b0;
    sweep_start = 1'b0;
    check("ld_busy_start", sweep_busy, 0);
    for (int k = 0; k < 16; k++) begin
      if (k % 3 == 1) begin
        cfg_valid = 1'b0;
        step();
        check($sformatf("ld_gap_y[%0d]", k), y, 0);
        check($sformatf("ld_gap_done[%0d]", k), cfg_done, 0);
      end
      if (k == 5) begin
        sweep_start = 1'b1;
        cfg_start = 1'b1;
      end
      cfg_valid = 1'b1;
      cfg_bit = xor_tt[k];
      step();
      sweep_start = 1'b0;
      cfg_start = 1'b0;
      check($sformatf("ld_y[%0d]", k), y, 0);
      check($sformatf("ld_busy[%0d]", k), sweep_busy, 0);
      check($sformatf("ld_done[%0d]", k), cfg_done, (k == 15) ? 1 : 0);
    end
    cfg_valid = 1'b0;
    step();
    check("ld_new_y", y, 1);
    check("ld_done_pulse", cfg_done, 0);
    for (int i = 0; i < 16; i++) begin
      in_v = 4'(i);
      step();
      check($sformatf("xor_y[%0d]", i), y, xor_tt[i]);
    end
    in_valid = 1'b0;

`ifdef LUT_EVAL_SWEEP_EN
    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("sw1_y[%0d]", k), sweep_y, xor_tt[k]);
      check($sformatf("sw1_done[%0d]", k), sweep_done, (k == 15) ? 1 : 0);
      if (k == 15) check("sw1_ones", ones, 8);
      step();
    end
`endif

    // Reset after 7 load bits: table reverts, no completion afterwards.
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      cfg_valid = 1'b1;
      cfg_bit = 1'b1;
      step();
    end
    cfg_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rld_done", cfg_done, 0);
    for (int k = 0; k < 9; k++) begin
      cfg_valid = 1'b1;
      cfg_bit = 1'b1;
      step();
      check($sformatf("rld_idle_done[%0d]", k), cfg_done, 0);
    end
    cfg_valid = 1'b0;
    in_valid = 1'b1;
    in_v = 4'd15;
    step();
    check("rld_y15", y, 1);
    in_v = 4'd1;
    step();
    check("rld_y1", y, 0);
    in_v = 4'd0;
    step();
    check("rld_y0", y, 0);
    in_valid = 1'b0;

`ifdef LUT_EVAL_SWEEP_EN
    // Reset after idx 9 of a sweep aborts it.
    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      check($sformatf("rsw_idx[%0d]", k), sweep_idx, k);
      if (k < 9) step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rsw_done", sweep_done, 0);
    check("rsw_ones", ones, 0);
    check("rsw_busy", sweep_busy, 0);
    check("rsw_valid", sweep_valid, 0);
    check("rsw_idx", sweep_idx, 0);
    step();
    check("rsw_idle_busy", sweep_busy, 0);
    check("rsw_idle_done", sweep_done, 0);
    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    check("rsw_restart_busy", sweep_busy, 1);
    check("rsw_restart_idx", sweep_idx, 0);
    for (int k = 0; k < 16; k++) step();
    check("rsw_restart_end", sweep_busy, 0);
    check("rsw_restart_ones", ones, 1);

    // N_IN = 1, INIT_TT = 2'b01.
    s1_start = 1'b1;
    step();
    s1_start = 1'b0;
    check("n1_valid0", d1_valid, 1);
    check("n1_idx0", d1_idx, 0);
    check("n1_y0", d1_sweep_y, 1);
    check("n1_done0", d1_done, 0);
    step();
    check("n1_idx1", d1_idx, 1);
    check("n1_y1", d1_sweep_y, 0);
    check("n1_done1", d1_done, 1);
    check("n1_ones", d1_ones, 1);
    step();
    check("n1_end_busy", d1_busy, 0);

    // N_IN = 8 must terminate after exactly 256 entries.
    begin
      int cnt;
      int done_at;
      int last_idx;
      cnt = 0;
      done_at = -1;
      last_idx = -1;
      s8_start = 1'b1;
      step();
      s8_start = 1'b0;
      while (d8_valid && cnt < 400) begin
        cnt++;
        last_idx = int'(d8_idx);
        if (d8_done) done_at = cnt;
        step();
      end
      check("n8_count", cnt, 256);
      check("n8_done_at", done_at, 256);
      check("n8_last_idx", last_idx, 255);
      check("n8_ones", d8_ones, 1);
      check("n8_busy_end", d8_busy, 0);
    end
`else
    s1_start = 1'b1;
    s8_start = 1'b1;
    step();
    s1_start = 1'b0;
    s8_start = 1'b0;
    check("n1_nosw_busy", d1_busy, 0);
    check("n8_nosw_valid", d8_valid, 0);
`endif

    d1_in_valid = 1'b1;
    d1_in = 1'b0;
    step();
    check("n1_eval0", d1_y, 1);
    d1_in = 1'b1;
    step();
    check("n1_eval1", d1_y, 0);
    d1_in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lut_eval.md
# lut_eval

Parametrised N-input boolean function evaluator that replaces fixed 4-input combinational test functions with a run-time programmable truth table. It provides a registered evaluation path, serial table loading, and a built-in exhaustive sweep that walks all 2^N_IN input combinations and reports each result. It sits between stimulus logic and checkers in the block-level test environment.

## Interface
- N_IN, 4, number of boolean inputs; legal range 1..8; table size TT = 2^N_IN.
- INIT_TT, TT'h0 with bit 2^N_IN-1 set (AND of all inputs), table contents after reset; bit k = output for input value k.
- clk_i  input  1  single clock; all logic is on its rising edge.
- rst_i  input  1  synchronous active-high reset.
- in_i  input  N_IN  evaluation input vector; bit N_IN-1 is the MSB (signal "a").
- in_valid_i  input  1  evaluate in_i this cycle.
- y_o  output  1  registered function result.
- y_valid_o  output  1  y_o is valid this cycle.
- cfg_start_i  input  1  begin table load (accepted in IDLE only).
- cfg_bit_i  input  1  serial table bit.
- cfg_valid_i  input  1  cfg_bit_i is valid (accepted in LOAD only).
- cfg_done_o  output  1  one-cycle pulse: new table is active.
- sweep_start_i  input  1  begin exhaustive sweep (accepted in IDLE only).
- sweep_busy_o  output  1  sweep in progress.
- sweep_idx_o  output  N_IN  input combination being reported.
- sweep_y_o  output  1  table value at sweep_idx_o.
- sweep_valid_o  output  1  sweep_idx_o and sweep_y_o are valid.
- sweep_done_o  output  1  one-cycle pulse on the last sweep entry.
- ones_o  output  N_IN+1  count of ones in the table; valid while sweep_done_o is high and held until the next sweep starts.

## Operation
- States: IDLE, LOAD, SWEEP. Reset puts the block in IDLE, sets active table = INIT_TT, and clears all outputs to 0, including ones_o, sweep_idx_o and the load bit counter.
- Evaluation:
  - In IDLE and LOAD, in_valid_i high produces y_o = active_tt[in_i] and y_valid_o = 1 on the next cycle.
  - When in_valid_i is low, y_valid_o = 0 on the next cycle and y_o holds its last value.
  - In SWEEP, in_valid_i is ignored and y_valid_o = 0.
- IDLE -> LOAD: on cfg_start_i. If cfg_start_i and sweep_start_i are high together, LOAD wins and the sweep request is dropped.
- LOAD:
  - The k-th accepted bit (k = 0..TT-1) is written to a shadow table at bit k.
  - The active table stays unchanged until the bit with k = TT-1 is accepted.
  - After that bit, shadow is copied to active, cfg_done_o pulses and the state returns to IDLE.
  - cfg_start_i and sweep_start_i are ignored during LOAD.
  - There is no abort. Only rst_i discards a partial load; the active table then becomes INIT_TT.
- IDLE -> SWEEP: on sweep_start_i (when cfg_start_i is low).
- SWEEP:
  - sweep_idx_o counts 0..TT-1, one index per cycle, with sweep_valid_o = 1 and sweep_y_o = active_tt[idx].
  - ones_o accumulates the count of ones.
  - sweep_done_o is high together with idx = TT-1. The state returns to IDLE on the following cycle.
  - The counter is N_IN+1 bits internally so that N_IN = 8 terminates without wrap-around.
- Reset during SWEEP aborts it: no sweep_done_o, and ones_o = 0.

## Timing
- Evaluation latency: 1 cycle. A new input is accepted every cycle.
- Load: with cfg_start_i at cycle t, bits are accepted from t+1. The last bit at cycle u gives cfg_done_o at u+1 and the new table active from u+1.
  - An evaluation sampled at u uses the old table.
  - An evaluation sampled at u+1 uses the new table.
- Sweep: with sweep_start_i at cycle t, sweep_busy_o and sweep_valid_o are high for cycles t+1..t+TT.
  - idx 0 appears at t+1.
  - sweep_done_o and the final ones_o appear at t+TT.
  - The block is in IDLE again at t+TT+1 and can accept a new start in that cycle.
- A start request in a non-IDLE state is not queued.

## Configuration
- LUT_EVAL_SWEEP_EN defined: the SWEEP state, sweep counter and ones accumulator are compiled in, and they behave as described above.
- LUT_EVAL_SWEEP_EN undefined:
  - sweep_start_i is ignored and the FSM has only IDLE and LOAD.
  - sweep_busy_o, sweep_valid_o, sweep_done_o, sweep_y_o, sweep_idx_o and ones_o are tied to 0.
  - Evaluation and load behaviour are unchanged.

## Test plan
- Reset default, N_IN=4: drive in_i = 0..15 one per cycle -> y_o = 1 only for in_i = 15, each result 1 cycle after the input; y_valid_o is 0 in the cycle after reset.
- Sweep after reset: pulse sweep_start_i -> 16 sweep_valid_o cycles with idx 0..15; sweep_y_o = 1 only at idx 15; sweep_done_o at idx 15; ones_o = 1; in_valid_i during the sweep gives y_valid_o = 0.
- Load 16'h6996 (XOR4, LSB first) with gaps in cfg_valid_i, evaluating in_i = 4'b0001 every cycle:
  - y_o = 0 until the cycle after cfg_done_o, then y_o = 1.
  - A following sweep reports ones_o = 8.
- Simultaneous cfg_start_i and sweep_start_i in IDLE -> LOAD entered and sweep_busy_o stays 0; sweep_start_i pulsed during LOAD -> ignored.
- Assert rst_i after 7 load bits, then after idx 9 of a sweep -> table reverts to 16'h8000, no cfg_done_o and no sweep_done_o, ones_o = 0, state is IDLE.
- N_IN=1, INIT_TT=2'b01, sweep -> 2 entries (y = 1, 0), sweep_done_o at t+2, ones_o = 1; N_IN=8 sweep -> 256 entries and terminates.
